// File: rtl/bus_pkg.sv
// Shared types and default sizes for the burst bus master: FSM state encoding,
// rw encoding and the default field lengths.
package bus_pkg;

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    REQ   = 4'd1,
    SEL   = 4'd2,
    ADDR  = 4'd3,
    BURST = 4'd4,
    WAIT  = 4'd5,
    WDATA = 4'd6,
    RDATA = 4'd7,
    DONE  = 4'd8
  } state_e;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam int DEF_ADDR_LEN    = 12;
  localparam int DEF_DATA_LEN    = 8;
  localparam int DEF_BURST_LEN   = 12;
  localparam int DEF_SLAVE_LEN   = 2;
  localparam int DEF_TIMEOUT_CYC = 255;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bus_shift_tx.sv
// Parallel-in serial-out shifter, LSB first. load has priority over shift;
// serial_out is always bit 0 of the register.
module bus_shift_tx #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] load_data,
  output logic             serial_out
);

  logic [WIDTH-1:0] sh_q, sh_d;

  always_comb begin
    sh_d = sh_q;
    if (load) begin
      sh_d = load_data;
    end else if (shift) begin
      sh_d = {1'b0, sh_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh_q <= '0;
    end else begin
      sh_q <= sh_d;
    end
  end

  assign serial_out = sh_q[0];

endmodule

// File: rtl/bus_master_burst.sv
// Serial burst bus master: arbitration, serial select/address/burst header,
// then burst_num+1 serial data beats. Optional REQ/WAIT timeout: MASTER_TIMEOUT_EN.
module bus_master_burst
  import bus_pkg::*;
#(
  parameter int ADDR_LEN    = DEF_ADDR_LEN,
  parameter int DATA_LEN    = DEF_DATA_LEN,
  parameter int BURST_LEN   = DEF_BURST_LEN,
  parameter int SLAVE_LEN   = DEF_SLAVE_LEN,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 rw,
  input  logic [ADDR_LEN-1:0]  address,
  input  logic [DATA_LEN-1:0]  wdata,
  input  logic [BURST_LEN-1:0] burst_num,
  input  logic [SLAVE_LEN-1:0] slave_select,
  input  logic                 approval_grant,
  input  logic                 busy,
  input  logic                 slave_ready,
  input  logic                 slave_valid,
  input  logic                 rx_data,
  output logic                 approval_request,
  output logic                 tx_line,
  output logic                 master_valid,
  output logic                 master_ready,
  output logic                 write_en,
  output logic                 read_en,
  output logic                 wdata_req,
  output logic [DATA_LEN-1:0]  rdata,
  output logic                 new_rx,
  output logic                 tx_done,
  output logic                 timeout_err,
  output logic [3:0]           state_dbg
);

  localparam int SW = max_int(max_int(ADDR_LEN, BURST_LEN), max_int(DATA_LEN, SLAVE_LEN));
  localparam int CW = $clog2(SW + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

`ifdef MASTER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  state_e               state_q, state_d;
  logic                 rw_q, rw_d;
  logic [ADDR_LEN-1:0]  addr_q, addr_d;
  logic [SLAVE_LEN-1:0] sel_q, sel_d;
  logic [BURST_LEN-1:0] burst_q, burst_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BURST_LEN:0]   beats_q, beats_d;
  logic [DATA_LEN-1:0]  rx_sh_q, rx_sh_d;
  logic [DATA_LEN-1:0]  rdata_q, rdata_d;
  logic                 new_rx_q, new_rx_d;
  logic                 wdata_req_q, wdata_req_d;
  logic [TW-1:0]        to_cnt_q, to_cnt_d;
  logic                 to_err_q, to_err_d;

  logic                 sh_load, sh_shift, sh_out;
  logic [SW-1:0]        sh_data;
  logic                 beat_last, to_hit;
  logic [DATA_LEN-1:0]  rx_next;

  // Beat counter is one bit wider than burst_num so an all-ones burst runs
  // 2^BURST_LEN beats without wrapping.
  assign beat_last = (beats_q == {1'b0, burst_q});
  assign to_hit    = TO_EN && (to_cnt_q == TW'(TIMEOUT_CYC - 1));
  assign rx_next   = {rx_data, rx_sh_q[DATA_LEN-1:1]};

  bus_shift_tx #(.WIDTH(SW)) u_shift_tx (
    .clk        (clk),
    .reset      (reset),
    .load       (sh_load),
    .shift      (sh_shift),
    .load_data  (sh_data),
    .serial_out (sh_out)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    sel_d       = sel_q;
    burst_d     = burst_q;
    cnt_d       = cnt_q;
    beats_d     = beats_q;
    rx_sh_d     = rx_sh_q;
    rdata_d     = rdata_q;
    new_rx_d    = 1'b0;
    wdata_req_d = 1'b0;
    to_cnt_d    = '0;
    to_err_d    = to_err_q;
    sh_load     = 1'b0;
    sh_shift    = 1'b0;
    sh_data     = '0;
    case (state_q)
      IDLE: begin
        to_err_d = 1'b0;
        if (start) begin
          rw_d    = rw;
          addr_d  = address;
          sel_d   = slave_select;
          burst_d = burst_num;
          cnt_d   = '0;
          beats_d = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (approval_grant && !busy) begin
          sh_load                   = 1'b1;
          sh_data[SLAVE_LEN-1:0]    = sel_q;
          cnt_d                     = '0;
          state_d                   = SEL;
        end else if (to_hit) begin
          to_err_d = 1'b1;
          state_d  = DONE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      SEL: begin
        if (cnt_q == CW'(SLAVE_LEN - 1)) begin
          sh_load                = 1'b1;
          sh_data[ADDR_LEN-1:0]  = addr_q;
          cnt_d                  = '0;
          state_d                = ADDR;
        end else begin
          sh_shift = 1'b1;
          cnt_d    = cnt_q + 1'b1;
        end
      end
      ADDR: begin
        if (cnt_q == CW'(ADDR_LEN - 1)) begin
          sh_load                = 1'b1;
          sh_data[BURST_LEN-1:0] = burst_q;
          cnt_d                  = '0;
          state_d                = BURST;
        end else begin
          sh_shift = 1'b1;
          cnt_d    = cnt_q + 1'b1;
        end
      end
      BURST: begin
        if (cnt_q == CW'(BURST_LEN - 1)) begin
          cnt_d   = '0;
          state_d = WAIT;
        end else begin
          sh_shift = 1'b1;
          cnt_d    = cnt_q + 1'b1;
        end
      end
      WAIT: begin
        if (slave_ready) begin
          cnt_d = '0;
          if (rw_q == RW_READ) begin
            state_d = RDATA;
          end else begin
            sh_load               = 1'b1;
            sh_data[DATA_LEN-1:0] = wdata;
            state_d               = WDATA;
          end
        end else if (to_hit) begin
          to_err_d = 1'b1;
          state_d  = DONE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      WDATA: begin
        if (cnt_q == CW'(DATA_LEN - 1)) begin
          cnt_d = '0;
          if (beat_last) begin
            state_d = DONE;
          end else begin
            beats_d     = beats_q + 1'b1;
            wdata_req_d = 1'b1;
            state_d     = WAIT;
          end
        end else begin
          sh_shift = 1'b1;
          cnt_d    = cnt_q + 1'b1;
        end
      end
      RDATA: begin
        // Bits only count on slave_valid; idle cycles leave the shifter untouched.
        if (slave_valid) begin
          rx_sh_d = rx_next;
          if (cnt_q == CW'(DATA_LEN - 1)) begin
            rdata_d  = rx_next;
            new_rx_d = 1'b1;
            cnt_d    = '0;
            if (beat_last) begin
              state_d = DONE;
            end else begin
              beats_d = beats_q + 1'b1;
              state_d = WAIT;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rw_q        <= 1'b0;
      addr_q      <= '0;
      sel_q       <= '0;
      burst_q     <= '0;
      cnt_q       <= '0;
      beats_q     <= '0;
      rx_sh_q     <= '0;
      rdata_q     <= '0;
      new_rx_q    <= 1'b0;
      wdata_req_q <= 1'b0;
      to_cnt_q    <= '0;
      to_err_q    <= 1'b0;
    end else begin
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      sel_q       <= sel_d;
      burst_q     <= burst_d;
      cnt_q       <= cnt_d;
      beats_q     <= beats_d;
      rx_sh_q     <= rx_sh_d;
      rdata_q     <= rdata_d;
      new_rx_q    <= new_rx_d;
      wdata_req_q <= wdata_req_d;
      to_cnt_q    <= to_cnt_d;
      to_err_q    <= to_err_d;
    end
  end

  always_comb begin
    approval_request = 1'b0;
    tx_line          = 1'b0;
    master_valid     = 1'b0;
    master_ready     = 1'b0;
    write_en         = 1'b0;
    read_en          = 1'b0;
    tx_done          = 1'b0;
    timeout_err      = 1'b0;
    case (state_q)
      REQ: begin
        approval_request = 1'b1;
      end
      SEL, ADDR, BURST, WDATA: begin
        approval_request = 1'b1;
        tx_line          = sh_out;
        master_valid     = 1'b1;
        write_en         = (rw_q == RW_WRITE);
        read_en          = (rw_q == RW_READ);
      end
      WAIT: begin
        approval_request = 1'b1;
        write_en         = (rw_q == RW_WRITE);
        read_en          = (rw_q == RW_READ);
      end
      RDATA: begin
        approval_request = 1'b1;
        master_ready     = 1'b1;
        write_en         = (rw_q == RW_WRITE);
        read_en          = (rw_q == RW_READ);
      end
      DONE: begin
        tx_done     = 1'b1;
        timeout_err = to_err_q;
      end
      default: begin
      end
    endcase
  end

  assign wdata_req = wdata_req_q;
  assign new_rx    = new_rx_q;
  assign rdata     = rdata_q;
  assign state_dbg = state_q;

endmodule
